// File: rtl/ddr_burst_stream_writer.sv
// -----------------------------------------------------------------------------
// ddr_burst_stream_writer
//
// Moves an AXI4-Stream of samples into DDR as fixed-length AXI4 INCR write
// bursts starting at a programmable base address. Supports one-shot and
// circular (ring-buffer) operation with a graceful stop that never truncates
// a burst. Only one burst is in flight at a time: the next AW is issued only
// after the B response of the current burst.
//
// Ports
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   cfg_start / cfg_stop   one-cycle start pulse / stop request
//   cfg_base_addr          buffer base (byte address, burst aligned)
//   cfg_num_bursts         bursts per pass
//   cfg_circular           0 = one-shot, 1 = wrap to base forever
//   s_axis_*               sample stream in (passed straight through to W)
//   m_axi_aw* / w* / b*    AXI4 write channels towards the interconnect
//   sts_busy               transfer in progress
//   sts_done               level, held until the next accepted start
//   sts_error              sticky, cleared by the next accepted start
//   sts_bursts             bursts completed (B accepted) since start
//   sts_wraps              completed circular passes
// -----------------------------------------------------------------------------
module ddr_burst_stream_writer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      cfg_start,
  input  logic                      cfg_stop,
  input  logic [ADDR_WIDTH-1:0]     cfg_base_addr,
  input  logic [CNT_WIDTH-1:0]      cfg_num_bursts,
  input  logic                      cfg_circular,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic                      sts_busy,
  output logic                      sts_done,
  output logic                      sts_error,
  output logic [CNT_WIDTH-1:0]      sts_bursts,
  output logic [CNT_WIDTH-1:0]      sts_wraps
);

  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int BURST_BYTES = BURST_LEN * STRB_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES_A = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  // Elaboration-time parameter sanity checks.
  generate
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64 && DATA_WIDTH != 128 && DATA_WIDTH != 256) begin : g_bad_dw
      $error("DATA_WIDTH must be 32, 64, 128 or 256");
    end
    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_len
      $error("BURST_LEN must be in 1..256");
    end
    if (BURST_BYTES > 4096) begin : g_bad_4k
      $error("BURST_LEN*DATA_WIDTH/8 must not exceed 4096 bytes");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH-1:0]   addr_q;      // address of the burst being issued
  logic [CNT_WIDTH-1:0]    num_q;
  logic                    circ_q;
  logic [CNT_WIDTH-1:0]    idx_q;       // burst index within the current pass
  logic [7:0]              beat_q;
  logic                    stop_q;
  logic [CNT_WIDTH-1:0]    bursts_q;
  logic [CNT_WIDTH-1:0]    wraps_q;
  logic                    error_q;
  logic                    done_q;

  logic active;
  logic start_ok;
  logic misaligned;
  logic w_hs;
  logic b_hs;
  logic b_err;
  logic pass_end;
  logic stop_eff;

  assign active     = state_q inside {S_ADDR, S_DATA, S_RESP};
  assign start_ok   = (state_q == S_IDLE) && cfg_start;
  assign misaligned = (cfg_base_addr % BURST_BYTES_A) != '0;
  assign w_hs       = (state_q == S_DATA) && s_axis_tvalid && m_axi_wready;
  assign b_hs       = (state_q == S_RESP) && m_axi_bvalid;
  assign b_err      = m_axi_bresp != 2'b00;
  assign pass_end   = (idx_q + CNT_WIDTH'(1)) == num_q;
  // A stop arriving together with the B response still ends the run there.
  assign stop_eff   = stop_q || cfg_stop;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = (misaligned || cfg_num_bursts == '0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: if (m_axi_awready) state_d = S_DATA;
      S_DATA: if (w_hs && beat_q == LAST_BEAT) state_d = S_RESP;
      S_RESP: begin
        if (m_axi_bvalid) begin
          if (b_err || stop_eff || (pass_end && !circ_q)) state_d = S_DONE;
          else                                             state_d = S_ADDR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs. W is a pure combinational pass-through of the stream so the
  // data path adds no latency; outside DATA the stream is held off.
  // ---------------------------------------------------------------------------
  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wlast   = 1'b0;
    s_axis_tready = 1'b0;
    m_axi_bready  = 1'b0;
    sts_busy      = 1'b0;
    unique case (state_q)
      S_ADDR: begin
        m_axi_awvalid = 1'b1;
        sts_busy      = 1'b1;
      end
      S_DATA: begin
        m_axi_wvalid  = s_axis_tvalid;
        m_axi_wdata   = s_axis_tdata;
        m_axi_wlast   = (beat_q == LAST_BEAT);
        s_axis_tready = m_axi_wready;
        sts_busy      = 1'b1;
      end
      S_RESP: begin
        m_axi_bready  = 1'b1;
        sts_busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: configuration latch, address walk, counters and status.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      base_q   <= '0;
      addr_q   <= '0;
      num_q    <= '0;
      circ_q   <= 1'b0;
      idx_q    <= '0;
      beat_q   <= '0;
      stop_q   <= 1'b0;
      bursts_q <= '0;
      wraps_q  <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (start_ok) begin
        base_q   <= cfg_base_addr;
        addr_q   <= cfg_base_addr;
        num_q    <= cfg_num_bursts;
        circ_q   <= cfg_circular;
        idx_q    <= '0;
        bursts_q <= '0;
        wraps_q  <= '0;
        stop_q   <= 1'b0;
        error_q  <= misaligned;
      end

      if (state_q == S_ADDR && m_axi_awready) beat_q <= '0;
      if (w_hs)                               beat_q <= beat_q + 8'd1;

      if (active && cfg_stop) stop_q <= 1'b1;

      if (b_hs) begin
        bursts_q <= bursts_q + CNT_WIDTH'(1);
        if (b_err) begin
          error_q <= 1'b1;
        end else if (pass_end) begin
          // End of a pass: rewind to base; count it only in circular mode.
          idx_q  <= '0;
          addr_q <= base_q;
          if (circ_q) wraps_q <= wraps_q + CNT_WIDTH'(1);
        end else begin
          idx_q  <= idx_q + CNT_WIDTH'(1);
          addr_q <= addr_q + BURST_BYTES_A;
        end
      end

      // done rises together with the DONE state and survives until restart.
      if (state_d == S_DONE) begin
        done_q <= 1'b1;
        stop_q <= 1'b0;
      end else if (start_ok) begin
        done_q <= 1'b0;
      end
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = LAST_BEAT;
  assign m_axi_awsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = '1;
  assign sts_done      = done_q;
  assign sts_error     = error_q;
  assign sts_bursts    = bursts_q;
  assign sts_wraps     = wraps_q;

endmodule

// File: tb/tb_ddr_burst_stream_writer.sv
// -----------------------------------------------------------------------------
// tb_ddr_burst_stream_writer
//
// Self-checking bench for ddr_burst_stream_writer (64-bit data, 16-beat
// bursts). A stream source feeds pre-generated random samples, a slave model
// answers AW/W/B with optional random stalls and a chosen SLVERR, and a
// monitor logs every handshake. Expected addresses, beat data, wlast
// positions and status counters are derived from the run configuration with
// plain arithmetic and compared after each run.
// -----------------------------------------------------------------------------
module tb_ddr_burst_stream_writer;

  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int BL    = 16;
  localparam int CW    = 32;
  localparam int SW    = DW / 8;
  localparam int BB    = BL * SW;
  localparam int MEM_N = 1024;

  logic            ACLK = 1'b0;
  logic            ARESETN = 1'b0;
  logic            cfg_start = 1'b0;
  logic            cfg_stop = 1'b0;
  logic [AW-1:0]   cfg_base_addr = '0;
  logic [CW-1:0]   cfg_num_bursts = '0;
  logic            cfg_circular = 1'b0;
  logic [DW-1:0]   s_axis_tdata = '0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic [AW-1:0]   m_axi_awaddr;
  logic [7:0]      m_axi_awlen;
  logic [2:0]      m_axi_awsize;
  logic [1:0]      m_axi_awburst;
  logic            m_axi_awvalid;
  logic            m_axi_awready = 1'b0;
  logic [DW-1:0]   m_axi_wdata;
  logic [SW-1:0]   m_axi_wstrb;
  logic            m_axi_wlast;
  logic            m_axi_wvalid;
  logic            m_axi_wready = 1'b0;
  logic [1:0]      m_axi_bresp = 2'b00;
  logic            m_axi_bvalid = 1'b0;
  logic            m_axi_bready;
  logic            sts_busy;
  logic            sts_done;
  logic            sts_error;
  logic [CW-1:0]   sts_bursts;
  logic [CW-1:0]   sts_wraps;

  always #5 ACLK = ~ACLK;

  ddr_burst_stream_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .CNT_WIDTH(CW)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_base_addr(cfg_base_addr), .cfg_num_bursts(cfg_num_bursts),
    .cfg_circular(cfg_circular),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_error(sts_error),
    .sts_bursts(sts_bursts), .sts_wraps(sts_wraps)
  );

  // ---------------------------------------------------------------------------
  // Comparison bookkeeping
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Environment: stream source, AXI slave, handshake monitor.
  // Handshakes are sampled on the falling edge (they complete on the next
  // rising edge); drivers change 1 ns after the rising edge.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] src_mem [MEM_N];
  int            src_ptr = 0;

  logic [AW-1:0] aw_log[$];
  logic [DW-1:0] w_log[$];
  bit            wl_log[$];
  int            b_cnt = 0;
  int            viol = 0;

  bit bp_en = 1'b0;
  bit gap_en = 1'b0;
  int err_at = 0;

  bit            t_hs = 1'b0, w_hs = 1'b0, a_hs = 1'b0, b_hs = 1'b0;
  bit            aw_hold = 1'b0, outstanding = 1'b0, pend_b = 1'b0;
  logic [AW-1:0] aw_hold_addr = '0;
  int            win_end = 0;
  int            aw_stall = 0, w_stall = 0;

  always begin : env
    @(negedge ACLK);
    if (ARESETN) begin
      t_hs = s_axis_tvalid && s_axis_tready;
      w_hs = m_axi_wvalid && m_axi_wready;
      a_hs = m_axi_awvalid && m_axi_awready;
      b_hs = m_axi_bvalid && m_axi_bready;
      // Inside a burst's W window the stream must pass straight through;
      // outside it neither side may move.
      if (w_log.size() < win_end) begin
        if (m_axi_wvalid !== s_axis_tvalid || s_axis_tready !== m_axi_wready) viol++;
        if (s_axis_tvalid && m_axi_wdata !== s_axis_tdata) viol++;
      end else if (s_axis_tready || m_axi_wvalid) begin
        viol++;
      end
      if (m_axi_awvalid && outstanding) viol++;
      if (aw_hold && (!m_axi_awvalid || m_axi_awaddr !== aw_hold_addr)) viol++;
      aw_hold      = m_axi_awvalid && !m_axi_awready;
      aw_hold_addr = m_axi_awaddr;
      if (a_hs) begin
        aw_log.push_back(m_axi_awaddr);
        win_end += BL;
        outstanding = 1'b1;
      end
      if (w_hs) begin
        w_log.push_back(m_axi_wdata);
        wl_log.push_back(m_axi_wlast);
        if (m_axi_wlast) pend_b = 1'b1;
      end
      if (t_hs) src_ptr++;
      if (b_hs) begin
        b_cnt++;
        outstanding = 1'b0;
        pend_b      = 1'b0;
      end
    end else begin
      t_hs = 1'b0; w_hs = 1'b0; a_hs = 1'b0; b_hs = 1'b0;
      aw_hold = 1'b0; outstanding = 1'b0; pend_b = 1'b0;
      win_end = w_log.size();
    end

    @(posedge ACLK);
    #1;
    if (!ARESETN) begin
      s_axis_tvalid = 1'b0;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      aw_stall      = 0;
      w_stall       = 0;
    end else begin
      // A presented beat stays valid until it is taken.
      if (!(s_axis_tvalid && !t_hs)) s_axis_tvalid = gap_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_axis_tdata = src_mem[src_ptr % MEM_N];
      if (bp_en) begin
        if (aw_stall > 0) aw_stall--;
        else if ($urandom_range(0, 3) == 0) aw_stall = 3;
        if (w_stall > 0) w_stall--;
        else if ($urandom_range(0, 4) == 0) w_stall = 3;
        m_axi_awready = (aw_stall == 0);
        m_axi_wready  = (w_stall == 0);
      end else begin
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
      end
      if (b_hs) m_axi_bvalid = 1'b0;
      if (!m_axi_bvalid && pend_b && (!bp_en || $urandom_range(0, 1) == 1)) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (b_cnt + 1 == err_at) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic step();
    @(posedge ACLK);
    #2;
  endtask

  // ---------------------------------------------------------------------------
  // One transfer: start it, optionally stop it, then check it against the
  // expectation derived from the configuration alone.
  // ---------------------------------------------------------------------------
  task automatic run(input string name, input logic [AW-1:0] base, input int n,
                     input bit circ, input int stop_at, input int err,
                     input bit bp, input bit gap, input bit stop_with_start);
    int a0, w0, v0, p0, t_exp, wraps_exp, na, nw;
    bit mis, done_seen, stopped;
    logic [AW-1:0] a_exp;

    a0 = aw_log.size(); w0 = w_log.size(); v0 = viol; p0 = src_ptr;
    bp_en = bp; gap_en = gap;
    err_at = (err > 0) ? b_cnt + err : 0;

    mis = (base % BB) != 0;
    if (mis || n == 0)     t_exp = 0;
    else if (err > 0)      t_exp = err;
    else if (stop_at > 0)  t_exp = stop_at;
    else                   t_exp = n;
    wraps_exp = (circ && t_exp > 0) ? (t_exp - ((err > 0) ? 1 : 0)) / n : 0;

    cfg_base_addr  = base;
    cfg_num_bursts = CW'(n);
    cfg_circular   = circ;
    cfg_start      = 1'b1;
    cfg_stop       = stop_with_start;
    step();
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    if (t_exp == 0) begin
      check({name, ":done_next_cycle"}, sts_done, 1'b1);
      check({name, ":busy_next_cycle"}, sts_busy, 1'b0);
    end

    done_seen = 1'b0;
    stopped   = 1'b0;
    for (int c = 0; c < 4000 && !done_seen; c++) begin
      if (sts_done) begin
        done_seen = 1'b1;
      end else begin
        cfg_stop = 1'b0;
        na = aw_log.size() - a0;
        nw = w_log.size() - w0;
        if (stop_at > 0 && !stopped && na == stop_at &&
            nw >= (stop_at - 1) * BL + 3 && nw < stop_at * BL) begin
          cfg_stop = 1'b1;
          stopped  = 1'b1;
        end
        step();
      end
    end
    cfg_stop = 1'b0;

    check({name, ":done_seen"}, done_seen, 1'b1);
    check({name, ":busy"},      sts_busy, 1'b0);
    check({name, ":error"},     sts_error, (mis || err > 0));
    check({name, ":bursts"},    sts_bursts, t_exp);
    check({name, ":wraps"},     sts_wraps, wraps_exp);
    check({name, ":aw_count"},  aw_log.size() - a0, t_exp);
    for (int i = 0; i < t_exp && a0 + i < aw_log.size(); i++) begin
      a_exp = base + AW'((i % n) * BB);
      check($sformatf("%s:awaddr%0d", name, i), aw_log[a0 + i], a_exp);
    end
    check({name, ":w_count"},   w_log.size() - w0, t_exp * BL);
    check({name, ":src_taken"}, src_ptr - p0, t_exp * BL);
    for (int j = 0; j < t_exp * BL && w0 + j < w_log.size(); j++) begin
      check($sformatf("%s:wdata%0d", name, j), w_log[w0 + j], src_mem[(p0 + j) % MEM_N]);
      check($sformatf("%s:wlast%0d", name, j), wl_log[w0 + j], (j % BL) == BL - 1);
    end
    check({name, ":protocol"}, viol - v0, 0);

    step();
    step();
    check({name, ":done_hold"}, sts_done, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int w0;
    for (int i = 0; i < MEM_N; i++) src_mem[i] = {$urandom(), $urandom()};

    ARESETN = 1'b0;
    repeat (3) step();
    check("rst:awvalid", m_axi_awvalid, 1'b0);
    check("rst:wvalid",  m_axi_wvalid, 1'b0);
    check("rst:wlast",   m_axi_wlast, 1'b0);
    check("rst:tready",  s_axis_tready, 1'b0);
    check("rst:bready",  m_axi_bready, 1'b0);
    check("rst:awaddr",  m_axi_awaddr, 0);
    check("rst:wdata",   m_axi_wdata, 0);
    check("rst:awlen",   m_axi_awlen, BL - 1);
    check("rst:awsize",  m_axi_awsize, 3);
    check("rst:awburst", m_axi_awburst, 2'b01);
    check("rst:wstrb",   m_axi_wstrb, 8'hFF);
    check("rst:busy",    sts_busy, 1'b0);
    check("rst:done",    sts_done, 1'b0);
    check("rst:error",   sts_error, 1'b0);
    check("rst:bursts",  sts_bursts, 0);
    check("rst:wraps",   sts_wraps, 0);
    ARESETN = 1'b1;
    repeat (2) step();

    // stop while idle must be ignored by the following run
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    step();

    run("oneshot",   32'h1000_0000, 4, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    run("circ_stop", 32'h0000_0000, 2, 1'b1, 5, 0, 1'b0, 1'b0, 1'b0);
    run("slverr",    32'h1000_0000, 4, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0);
    run("misalign",  32'h1000_0008, 4, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    run("zero",      32'h1000_0000, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    run("start_stop",32'h1000_0000, 2, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    run("rand_bp",   AW'($urandom()) & 32'hFFFF_FF80, $urandom_range(3, 6),
        1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    run("top_wrap",  32'hFFFF_FF00, 4, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    run("circ_rand", AW'($urandom()) & 32'hFFFF_FF80, 3, 1'b1,
        $urandom_range(4, 8), 0, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a data phase
    bp_en = 1'b1; gap_en = 1'b1; err_at = 0;
    w0 = w_log.size();
    cfg_base_addr = 32'h2000_0000; cfg_num_bursts = 4; cfg_circular = 1'b0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int c = 0; c < 2000 && !(w_log.size() - w0 >= 20 && m_axi_wvalid); c++) step();
    check("midrst:wvalid_before", m_axi_wvalid, 1'b1);
    #1 ARESETN = 1'b0;
    #1;
    check("midrst:awvalid", m_axi_awvalid, 1'b0);
    check("midrst:wvalid",  m_axi_wvalid, 1'b0);
    check("midrst:tready",  s_axis_tready, 1'b0);
    check("midrst:bready",  m_axi_bready, 1'b0);
    check("midrst:busy",    sts_busy, 1'b0);
    repeat (3) step();
    ARESETN = 1'b1;
    step();
    check("postrst:bursts", sts_bursts, 0);
    check("postrst:done",   sts_done, 1'b0);
    run("post_rst", 32'h2000_0000, 3, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
